// File: rtl/jtframe_mc2_segajoy.sv
// Sega Mega Drive 3/6-button pad reader for the two Multicore 2 DB9 ports.
// Drives the shared select line (pin 7) through an 8-phase scan followed by a
// long idle gap, samples both ports in parallel and publishes glitch-free,
// active-high 12-bit button words once per scan.
//
// Ports
//   clk_sys            system clock
//   rst                synchronous, active-high reset
//   joyN_*_i           port N pins (up, down, left, right, p6, p9), active-low, async
//   joyX_p7_o          select line shared by both ports
//   joy1_o / joy2_o    {Mode,X,Y,Z,Start,A,C,B,up,down,left,right}, active-high
//   pad1_ok / pad2_ok  Sega pad present on the port
//   six1 / six2        6-button pad present on the port
//   upd                one-cycle strobe on the cycle the words change
module jtframe_mc2_segajoy #(
  parameter int PHASE_CYC = 480,
  parameter int IDLE_CYC  = 96000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        joy1_up_i,
  input  logic        joy1_down_i,
  input  logic        joy1_left_i,
  input  logic        joy1_right_i,
  input  logic        joy1_p6_i,
  input  logic        joy1_p9_i,
  input  logic        joy2_up_i,
  input  logic        joy2_down_i,
  input  logic        joy2_left_i,
  input  logic        joy2_right_i,
  input  logic        joy2_p6_i,
  input  logic        joy2_p9_i,
  output logic        joyX_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        pad1_ok,
  output logic        pad2_ok,
  output logic        six1,
  output logic        six2,
  output logic        upd
);

  localparam int MAXC = (PHASE_CYC > IDLE_CYC) ? PHASE_CYC : IDLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PH_RL   = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] IDLE_RL = CW'(IDLE_CYC - 1);

  // PHn is encoded as n+1, so the select-high phases (IDLE, PH0/2/4/6)
  // are exactly code 0 and the odd codes.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PH0  = 4'd1;
  localparam logic [3:0] S_PH1  = 4'd2;
  localparam logic [3:0] S_PH5  = 4'd6;
  localparam logic [3:0] S_PH6  = 4'd7;
  localparam logic [3:0] S_PH7  = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          pend_q, upd_q;
  logic          last;

  logic [11:0]      sync1_q, sync2_q;
  logic [1:0][5:0]  pin_a;  // per port {up,down,left,right,p6,p9}, 1 = low

  logic [1:0][3:0]  dir_q;  // {up,down,left,right}
  logic [1:0][3:0]  zyxm_q; // {Z,Y,X,Mode}
  logic [1:0]       b_q, c_q, a_q, st_q, pres_q, six_q;

  logic [1:0][11:0] word_q, word_d;
  logic [1:0]       ok_q, ok_d, sixo_q, sixo_d;

  assign pin_a = ~sync2_q;
  assign last  = (cnt_q == '0);

  // Scan sequencer: one down-counter paces every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    sel_d   = sel_q;
    if (last) begin
      if (state_q >= S_PH7) state_d = S_IDLE;
      else                  state_d = state_q + 4'd1;
      cnt_d = (state_d == S_IDLE) ? IDLE_RL : PH_RL;
      sel_d = (state_d == S_IDLE) || state_d[0];
    end
  end

  // Word assembly from the shadow samples of the finished scan.
  always_comb begin
    word_d = word_q;
    ok_d   = ok_q;
    sixo_d = sixo_q;
    for (int p = 0; p < 2; p++) begin
      if (pres_q[p]) begin
        word_d[p] = {(six_q[p] ? {zyxm_q[p][0], zyxm_q[p][1], zyxm_q[p][2], zyxm_q[p][3]} : 4'b0000),
                     st_q[p], a_q[p], c_q[p], b_q[p], dir_q[p]};
        sixo_d[p] = six_q[p];
      end else begin
        // Atari stick or empty port: only the select-high view is meaningful.
        word_d[p] = {6'b000000, c_q[p], b_q[p], dir_q[p]};
        sixo_d[p] = 1'b0;
      end
      ok_d[p] = pres_q[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= IDLE_RL;
      sel_q   <= 1'b1;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      word_q  <= '0;
      ok_q    <= '0;
      sixo_q  <= '0;
    end else begin
      // Stage: pin synchronizer.
      sync1_q <= {joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i,
                  joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i};
      sync2_q <= sync1_q;
      // Stage: sequencer.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      // Stage: publish one cycle after the scan closes.
      pend_q  <= last && (state_q == S_PH7);
      upd_q   <= pend_q;
      if (pend_q) begin
        word_q <= word_d;
        ok_q   <= ok_d;
        sixo_q <= sixo_d;
      end
    end
  end

  // Shadow sampling on the last cycle of each phase; stale contents after an
  // aborted scan are harmless because every field is rewritten before the
  // next publish.
  always_ff @(posedge clk_sys) begin
    if (last) begin
      for (int p = 0; p < 2; p++) begin
        case (state_q)
          S_PH0: begin
            dir_q[p] <= pin_a[p][5:2];
            b_q[p]   <= pin_a[p][1];
            c_q[p]   <= pin_a[p][0];
          end
          S_PH1: begin
            a_q[p]    <= pin_a[p][1];
            st_q[p]   <= pin_a[p][0];
            pres_q[p] <= pin_a[p][3] & pin_a[p][2];
          end
          S_PH5: six_q[p]  <= &pin_a[p][5:2];
          S_PH6: zyxm_q[p] <= pin_a[p][5:2];
          default: ;
        endcase
      end
    end
  end

  assign joyX_p7_o = sel_q;
  assign joy1_o    = word_q[0];
  assign joy2_o    = word_q[1];
  assign pad1_ok   = ok_q[0];
  assign pad2_ok   = ok_q[1];
  assign six1      = sixo_q[0];
  assign six2      = sixo_q[1];
  assign upd       = upd_q;

endmodule

// File: tb/tb_jtframe_mc2_segajoy.sv
module tb_jtframe_mc2_segajoy;
  localparam int P = 4;
  localparam int I = 10;
  localparam int PER = 8 * P + I;

  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i;
  logic joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i;
  logic joyX_p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic pad1_ok, pad2_ok, six1, six2, upd;

  jtframe_mc2_segajoy #(.PHASE_CYC(P), .IDLE_CYC(I)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .joy1_up_i(joy1_up_i), .joy1_down_i(joy1_down_i), .joy1_left_i(joy1_left_i),
    .joy1_right_i(joy1_right_i), .joy1_p6_i(joy1_p6_i), .joy1_p9_i(joy1_p9_i),
    .joy2_up_i(joy2_up_i), .joy2_down_i(joy2_down_i), .joy2_left_i(joy2_left_i),
    .joy2_right_i(joy2_right_i), .joy2_p6_i(joy2_p6_i), .joy2_p9_i(joy2_p9_i),
    .joyX_p7_o(joyX_p7_o), .joy1_o(joy1_o), .joy2_o(joy2_o),
    .pad1_ok(pad1_ok), .pad2_ok(pad2_ok), .six1(six1), .six2(six2), .upd(upd)
  );

  int checks = 0;
  int failures = 0;

  // Pad kinds: 0 = Atari stick / nothing, 1 = 3-button, 2 = 6-button.
  int t1 = 0, t2 = 0;
  logic [11:0] b1 = '0, b2 = '0;

  // 6-button pad internal counter: counts select falls, clears after a long high.
  int pcnt = 0;
  int hr = 0;
  logic sprev = 1'b1;
  always @(posedge clk_sys) begin
    sprev <= joyX_p7_o;
    if (joyX_p7_o) hr <= hr + 1; else hr <= 0;
    if (joyX_p7_o && hr >= 6) pcnt <= 0;
    else if (!joyX_p7_o && sprev) pcnt <= pcnt + 1;
  end

  // Returns {up,down,left,right,p6,p9} pin levels (active-low) for a pad.
  function automatic logic [5:0] padpins(int t, logic [11:0] b, logic sel, int c);
    logic [5:0] p;
    case (t)
      0: p = ~{b[3], b[2], b[1], b[0], b[4], b[5]};
      1: p = sel ? ~{b[3], b[2], b[1], b[0], b[4], b[5]}
                 : ~{b[3], b[2], 1'b1, 1'b1, b[6], b[7]};
      default: begin
        if (sel) p = (c == 3) ? ~{b[8], b[9], b[10], b[11], b[4], b[5]}
                              : ~{b[3], b[2], b[1], b[0], b[4], b[5]};
        else if (c == 3) p = ~{4'b1111, b[6], b[7]};
        else p = ~{b[3], b[2], 1'b1, 1'b1, b[6], b[7]};
      end
    endcase
    return p;
  endfunction

  assign {joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i} =
    padpins(t1, b1, joyX_p7_o, pcnt);
  assign {joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i} =
    padpins(t2, b2, joyX_p7_o, pcnt);

  // Reference: what the word should be for a pad kind holding button set b.
  function automatic logic [11:0] exp_word(int t, logic [11:0] b);
    if (t == 2) return b;
    if (t == 1) return b & 12'h0FF;
    return b & 12'h03F;
  endfunction

  // Keep random button sets physically meaningful for the pad kind.
  function automatic logic [11:0] legal(int t, logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (t == 1 && r[3] && r[2]) r[3] = 1'b0;
    if (t == 0 && r[0] && r[1]) r[1] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_sel(int n);
    int m;
    if (n < I) return 1'b1;
    m = (n - I) % PER;
    if (m >= 8 * P) return 1'b1;
    return ((m / P) % 2) == 0;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_upd(input string nm, output bit got);
    got = 1'b0;
    for (int k = 0; k < 4 * PER && !got; k++) begin
      @(negedge clk_sys);
      if (upd) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s upd timeout actual=0 required=1", nm);
    end
  endtask

  task automatic check_ports(input string nm, input logic [11:0] e1, input logic k1,
                             input logic s1, input logic [11:0] e2, input logic k2,
                             input logic s2);
    chk({nm, "_joy1"}, joy1_o, e1);
    chk({nm, "_ok1"}, pad1_ok, k1);
    chk({nm, "_six1"}, six1, s1);
    chk({nm, "_joy2"}, joy2_o, e2);
    chk({nm, "_ok2"}, pad2_ok, k2);
    chk({nm, "_six2"}, six2, s2);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
  endtask

  typedef struct {
    int t1; logic [11:0] b1; int t2; logic [11:0] b2;
    logic [11:0] e1; logic k1; logic s1;
    logic [11:0] e2; logic k2; logic s2;
  } vec_t;

  vec_t vt[5];

  initial begin
    bit got;
    int n;
    logic [11:0] s0;

    vt[0] = '{2, 12'hCC0, 1, 12'h038, 12'hCC0, 1'b1, 1'b1, 12'h038, 1'b1, 1'b0};
    vt[1] = '{0, 12'h000, 1, 12'h038, 12'h000, 1'b0, 1'b0, 12'h038, 1'b1, 1'b0};
    vt[2] = '{0, 12'h011, 2, 12'h123, 12'h011, 1'b0, 1'b0, 12'h123, 1'b1, 1'b1};
    vt[3] = '{2, 12'hFFF, 2, 12'h000, 12'hFFF, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
    vt[4] = '{1, 12'hFF7, 0, 12'h03D, 12'h0F7, 1'b1, 1'b0, 12'h03D, 1'b0, 1'b0};

    t1 = vt[0].t1; b1 = vt[0].b1; t2 = vt[0].t2; b2 = vt[0].b2;
    rst = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_ports("reset", 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("reset_upd", upd, 1'b0);
    chk("reset_sel", joyX_p7_o, 1'b1);
    rst = 1'b0;

    // Table vectors, each applied during idle and checked at the next upd.
    for (int i = 0; i < 5; i++) begin
      t1 = vt[i].t1; b1 = vt[i].b1; t2 = vt[i].t2; b2 = vt[i].b2;
      wait_upd($sformatf("vec%0d", i), got);
      if (got) check_ports($sformatf("vec%0d", i), vt[i].e1, vt[i].k1, vt[i].s1,
                           vt[i].e2, vt[i].k2, vt[i].s2);
    end

    // Random pads and buttons against the reference.
    for (int i = 0; i < 16; i++) begin
      t1 = int'($urandom_range(0, 2));
      t2 = int'($urandom_range(0, 2));
      b1 = legal(t1, 12'($urandom));
      b2 = legal(t2, 12'($urandom));
      wait_upd($sformatf("rnd%0d", i), got);
      if (got) check_ports($sformatf("rnd%0d", i), exp_word(t1, b1), t1 != 0, t1 == 2,
                           exp_word(t2, b2), t2 != 0, t2 == 2);
    end

    // Mid-scan change: B (sampled in PH0) is missed, X (sampled in PH6) is caught.
    t1 = 2; s0 = 12'h0C0; b1 = s0;
    wait_upd("mid_setup", got);
    got = 1'b0;
    for (int k = 0; k < 2 * PER && !got; k++) begin
      @(negedge clk_sys);
      if (!joyX_p7_o) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL mid_sel_fall actual=1 required=0");
    end
    b1 = s0 ^ 12'h410;
    got = 1'b0;
    for (int k = 0; k < 2 * PER && !got; k++) begin
      @(negedge clk_sys);
      if (upd) got = 1'b1;
      else chk($sformatf("mid_hold%0d", k), joy1_o, s0);
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL mid_upd timeout actual=0 required=1");
    end else chk("mid_upd_word", joy1_o, s0 ^ 12'h400);
    wait_upd("mid_next", got);
    if (got) chk("mid_next_word", joy1_o, s0 ^ 12'h410);

    // Select waveform, first PH0 position and upd spacing after reset release.
    t1 = 2; b1 = 12'h0C0;
    do_reset();
    for (n = 0; n <= 2 * PER + 1; n++) begin
      if (n > 0) @(negedge clk_sys);
      chk($sformatf("wave_sel%0d", n), joyX_p7_o, exp_sel(n));
      chk($sformatf("wave_upd%0d", n), upd, (n == PER + 1) || (n == 2 * PER + 1));
      chk($sformatf("wave_joy%0d", n), joy1_o, (n <= PER) ? 12'h000 : 12'h0C0);
    end

    // Reset asserted in PH3 aborts the scan.
    do_reset();
    for (n = 1; n <= I + 3 * P + 1; n++) begin
      @(negedge clk_sys);
      chk($sformatf("abort_pre_upd%0d", n), upd, 1'b0);
    end
    chk("abort_in_ph3", joyX_p7_o, 1'b0);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("abort_upd", upd, 1'b0);
    chk("abort_joy1", joy1_o, 12'h000);
    chk("abort_ok1", pad1_ok, 1'b0);
    chk("abort_sel", joyX_p7_o, 1'b1);
    rst = 1'b0;
    got = 1'b0;
    for (n = 1; n <= 2 * PER && !got; n++) begin
      @(negedge clk_sys);
      if (upd) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL abort_next_upd timeout actual=0 required=1");
    end else begin
      chk("abort_next_upd_dist", 12'(n - 1), 12'(PER + 1));
      chk("abort_next_joy1", joy1_o, 12'h0C0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_mc2_segajoy.md
# jtframe_mc2_segajoy

Reads two Sega Mega Drive 3/6-button pads on the Multicore 2 DB9 ports: it drives the shared select line and samples the six pad pins of each port. It produces decoded, active-high, glitch-free button words for both players. It sits directly upstream of the MC2 frame top level: its pin-side ports connect to the `joy1_*_i`, `joy2_*_i` and `joyX_p7_o` board pins, and its words feed the board joystick inputs.

## Interface
Parameters:
- PHASE_CYC, 480 — clk_sys cycles per select half-phase (10 µs at 48 MHz); minimum 4.
- IDLE_CYC, 96000 — clk_sys cycles with select high between scans (2 ms, above the pad's 1.5 ms 6-button counter timeout); minimum 1.

Ports:
- clk_sys  in  1  — system clock; the only clock.
- rst  in  1  — reset; synchronous, active-high.
- joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i  in  1 each  — port 1 pins, active-low, asynchronous.
- joy2_up_i … joy2_p9_i  in  1 each  — port 2 pins, same set and meaning as port 1.
- joyX_p7_o  out  1  — select line (pin 7), shared by both ports.
- joy1_o  out  12  — player 1 buttons, active-high. Bit order: [0]right, [1]left, [2]down, [3]up, [4]B, [5]C, [6]A, [7]Start, [8]Z, [9]Y, [10]X, [11]Mode.
- joy2_o  out  12  — player 2 buttons, same bit order as joy1_o.
- pad1_ok, pad2_ok  out  1 each  — Sega pad detected on the port.
- six1, six2  out  1 each  — 6-button pad detected on the port.
- upd  out  1  — one-cycle strobe marking the cycle the output words change.

## Operation
Input conditioning:
- All 12 pins pass through a 2-flop synchronizer, then are inverted so that 1 means pressed or low.
- Each sample below uses the synchronized, inverted value.

State machine: IDLE → PH0 … PH7 → IDLE.
- Select is high in IDLE and in PH0, PH2, PH4 and PH6.
- Select is low in PH1, PH3, PH5 and PH7.
- One counter ($clog2 of max(PHASE_CYC, IDLE_CYC) bits) counts down in every state.
- The state advances when the counter reaches 0; the counter then reloads with PHASE_CYC−1, or IDLE_CYC−1 on entry to IDLE.

Per-port sampling, taken on the last cycle of each phase:
- PH0: up, down, left, right, B = p6, C = p9.
- PH1: A = p6, Start = p9; present = left AND right (both pins low).
- PH5: six = up AND down AND left AND right.
- PH6: Z = up, Y = down, X = left, Mode = right.
- PH2, PH3, PH4 and PH7 are not sampled.

Samples are held in shadow registers. On the cycle after the PH7 sample, all outputs update together:
- present = 1: pad_ok = 1; the word is formed from the shadow registers.
- present = 0 (Atari-style or nothing plugged): pad_ok = 0 and six = 0; directions come from PH0; B = p6 and C = p9 from PH0; A, Start, X, Y, Z and Mode are 0.
- six = 0 on a present pad: bits [11:8] are 0.
- upd = 1 for exactly this cycle.

Outputs hold their values between updates. Both ports are processed in the same cycles.

## Timing
- Reset (synchronous) sets state to IDLE, counter to IDLE_CYC−1 and select to 1. All words, pad_ok, six and upd become 0, and the synchronizers are cleared.
- Asserting reset in the middle of a scan aborts it. Shadow registers are discarded and no upd is issued.
- The first PH0 begins IDLE_CYC cycles after rst is released.
- Scan period is 8·PHASE_CYC + IDLE_CYC cycles; upd fires once per period.
- joyX_p7_o is registered and changes on the cycle of each state transition.
- Pin-to-output latency: 2 synchronizer cycles plus the time to the next PH7 end plus 1 cycle.
- Sampling on the last cycle of a phase guarantees PHASE_CYC−3 cycles of settle time after each select edge.
- A button that changes in mid-scan shows up only if the change falls before its sample cycle; otherwise it appears in the next scan. The output word is never a mix of two partial scans.

## Test plan
- 6-button pad model on port 1 (responds to the select edge count, resets after 1.5 ms), with A, Start, X and Mode held → after the first upd, joy1_o = 12'hC00 | 12'h0C0 = 12'hCC0, pad1_ok = 1, six1 = 1.
- 3-button pad model on port 2 (PH5 returns the normal directions), with up, B and C held → joy2_o = 12'h038, pad2_ok = 1, six2 = 0.
- All port-1 pins floating high (nothing plugged) → joy1_o = 0, pad1_ok = 0, six1 = 0; with p6 low and right low → joy1_o = 12'h011, pad1_ok = 0.
- PHASE_CYC = 4, IDLE_CYC = 10: check select waveform 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 10 cycles; upd spacing is exactly 42 cycles; first PH0 begins 10 cycles after reset release.
- rst pulsed during PH3 with buttons held → upd stays 0, outputs stay 0 and select is high the next cycle; the next valid upd comes IDLE_CYC + 8·PHASE_CYC + 1 cycles after release.
- Button toggled between the PH0 and PH7 samples → the old value stays on the output until upd, and the output changes only on the upd cycle.
